// File: rtl/mp_imem_arb.sv
// mp_imem_arb -- two-port arbiter in front of the single-ported instruction memory.
//
// Arbitrates instruction fetch (IF) against a load/debug read port (LS) that
// reads instruction space. One grant per cycle at most. IF normally wins a
// contended cycle, but once LS has been denied STARVE_LIMIT cycles in a row it
// is forced ahead for one grant. Memory read data returns one cycle after the
// access and is steered back as a per-port valid strobe on a shared data bus.
//
// Ports:
//   sys_clk, sys_rst       clock (rising edge), async active-high reset
//   if_req/if_addr         fetch request, held until if_gnt
//   if_flush               kills a fetch read granted this cycle or returning now
//   if_gnt                 fetch accepted this cycle (combinational)
//   if_vld/if_data         fetch response strobe / data
//   ls_req/ls_addr         LS request, held until ls_gnt
//   ls_gnt                 LS accepted this cycle (combinational)
//   ls_vld/ls_data         LS response strobe / data
//   mem_cen/mem_a          memory chip enable (active low) / word address
//   mem_q                  memory read data, valid the cycle after mem_cen low
module mp_imem_arb #(
    parameter int AW           = 30,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_vld,
    output logic [DW-1:0] if_data,
    input  logic          ls_req,
    input  logic [AW-1:0] ls_addr,
    output logic          ls_gnt,
    output logic          ls_vld,
    output logic [DW-1:0] ls_data,
    output logic          mem_cen,
    output logic [AW-1:0] mem_a,
    input  logic [DW-1:0] mem_q
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    owner_e        owner_q, owner_d;
    logic [CW-1:0] starve_cnt, cnt_d;
    logic          force_ls, force_d;
    logic          if_vld_q, if_vld_d;

    // ------------------------------------------------------------------
    // Arbitration: IF has priority unless LS has been starved long enough.
    // ------------------------------------------------------------------
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (if_req && ls_req) begin
            if (force_ls) ls_gnt = 1'b1;
            else          if_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end else if (ls_req) begin
            ls_gnt = 1'b1;
        end
    end

    // Idle address follows if_addr so the bus does not toggle needlessly.
    assign mem_cen = ~(if_gnt | ls_gnt);
    assign mem_a   = ls_gnt ? ls_addr : if_addr;

    // ------------------------------------------------------------------
    // Starvation tracking. force_ls is registered from the next count so it
    // is exactly (starve_cnt >= STARVE_LIMIT) without a compare in the
    // grant path.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = '0;
        if (ls_req && !ls_gnt)
            cnt_d = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
        force_d = (cnt_d >= LIMIT);
    end

    // ------------------------------------------------------------------
    // Ownership of the in-flight read (next-state logic).
    // ------------------------------------------------------------------
    always_comb begin
        owner_d  = OWN_NONE;
        if_vld_d = 1'b0;
        if (if_gnt) begin
            owner_d  = OWN_IF;
            // A flush in the grant cycle kills the read; the access still
            // goes to memory since mem_cen is already low.
            if_vld_d = ~if_flush;
        end else if (ls_gnt) begin
            owner_d  = OWN_LS;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= '0;
            force_ls   <= 1'b0;
            if_vld_q   <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            starve_cnt <= cnt_d;
            force_ls   <= force_d;
            if_vld_q   <= if_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Response steering. A flush raised in the return cycle also drops the
    // strobe, so the fetch unit never sees data from a redirected stream.
    // ------------------------------------------------------------------
    assign if_vld  = if_vld_q & (owner_q == OWN_IF) & ~if_flush;
    assign ls_vld  = (owner_q == OWN_LS);
    assign if_data = mem_q;
    assign ls_data = mem_q;

endmodule

// File: tb/tb_mp_imem_arb.sv
// Self-checking bench for mp_imem_arb. A small memory model answers reads one
// cycle after mem_cen low. A monitor predicts grants from an independent model
// of the arbitration rules, pushes expected responses into per-port queues and
// pops them when the strobes are due. Scenario tasks add targeted checks.
module tb_mp_imem_arb;
    localparam int AW = 30;
    localparam int DW = 32;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          if_req = 1'b0, if_flush = 1'b0, ls_req = 1'b0;
    logic [AW-1:0] if_addr = '0, ls_addr = '0;
    logic          if_gnt, if_vld, ls_gnt, ls_vld, mem_cen;
    logic [DW-1:0] if_data, ls_data, mem_q;
    logic [AW-1:0] mem_a;

    int n_pass = 0;
    int n_total = 0;

    mp_imem_arb dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst),
        .if_req  (if_req),  .if_addr (if_addr), .if_flush(if_flush),
        .if_gnt  (if_gnt),  .if_vld  (if_vld),  .if_data (if_data),
        .ls_req  (ls_req),  .ls_addr (ls_addr),
        .ls_gnt  (ls_gnt),  .ls_vld  (ls_vld),  .ls_data (ls_data),
        .mem_cen (mem_cen), .mem_a   (mem_a),   .mem_q   (mem_q)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        if (a == 30'h100) return 32'hDEADBEEF;
        return {a[27:0], 4'h5} ^ 32'hA5C3_0000;
    endfunction

    // Memory macro model.
    always @(posedge sys_clk)
        if (!mem_cen) mem_q <= word(mem_a);

    // ------------------------------------------------------------------
    // Scoreboard monitor: samples 3 time units after the negedge on which
    // inputs are driven, i.e. well before the next rising edge.
    // ------------------------------------------------------------------
    logic [DW-1:0] if_q[$];
    logic [DW-1:0] ls_q[$];
    int            m_cnt = 0;

    always @(posedge sys_rst) begin
        if_q.delete();
        ls_q.delete();
        m_cnt = 0;
    end

    always @(negedge sys_clk) begin
        logic    e_if, e_ls, e_force;
        logic [DW-1:0] d;
        #3;
        if (sys_rst) begin
            n_total++;
            if ({if_vld, ls_vld} !== 2'b00)
                $display("FAIL vld_in_reset: got %b want 00", {if_vld, ls_vld});
            else n_pass++;
        end else begin
            // responses due this cycle
            if (if_q.size() != 0) begin
                d = if_q.pop_front();
                n_total++;
                if (if_vld !== ~if_flush)
                    $display("FAIL sb_if_vld: got %b want %b", if_vld, ~if_flush);
                else n_pass++;
                if (!if_flush) begin
                    n_total++;
                    if (if_data !== d) $display("FAIL sb_if_data: got %h want %h", if_data, d);
                    else n_pass++;
                end
            end else begin
                n_total++;
                if (if_vld !== 1'b0) $display("FAIL sb_if_idle: got %b want 0", if_vld);
                else n_pass++;
            end
            if (ls_q.size() != 0) begin
                d = ls_q.pop_front();
                n_total++;
                if (ls_vld !== 1'b1 || ls_data !== d)
                    $display("FAIL sb_ls_resp: got vld=%b data=%h want vld=1 data=%h", ls_vld, ls_data, d);
                else n_pass++;
            end else begin
                n_total++;
                if (ls_vld !== 1'b0) $display("FAIL sb_ls_idle: got %b want 0", ls_vld);
                else n_pass++;
            end
            // arbitration model
            e_force = (m_cnt >= 4);
            e_ls    = ls_req && (!if_req || e_force);
            e_if    = if_req && !e_ls;
            n_total++;
            if ({if_gnt, ls_gnt, mem_cen} !== {e_if, e_ls, ~(e_if | e_ls)})
                $display("FAIL sb_grant: got if=%b ls=%b cen=%b want if=%b ls=%b cen=%b",
                         if_gnt, ls_gnt, mem_cen, e_if, e_ls, ~(e_if | e_ls));
            else n_pass++;
            if (e_if || e_ls) begin
                n_total++;
                if (mem_a !== (e_ls ? ls_addr : if_addr))
                    $display("FAIL sb_mem_a: got %h want %h", mem_a, e_ls ? ls_addr : if_addr);
                else n_pass++;
            end
            if (e_if && !if_flush) if_q.push_back(word(if_addr));
            if (e_ls) ls_q.push_back(word(ls_addr));
            if (ls_req && !e_ls) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
            else                 m_cnt = 0;
        end
    end

    // Drive one cycle's inputs on the negedge, then settle to the check point.
    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic fl,
                         input logic lr, input logic [AW-1:0] la);
        @(negedge sys_clk);
        if_req = ir; if_addr = ia; if_flush = fl; ls_req = lr; ls_addr = la;
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, if_addr, 1'b0, 1'b0, ls_addr);
    endtask

    task automatic test_reset;
        #1;
        n_total++;
        if ({if_vld, ls_vld} !== 2'b00) $display("FAIL reset_vld: got %b want 00", {if_vld, ls_vld});
        else n_pass++;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, '0);
            n_total++;
            if ({mem_cen, if_vld, ls_vld, if_gnt, ls_gnt} !== 5'b10000)
                $display("FAIL reset_idle: got cen,ifv,lsv,ifg,lsg=%b want 10000",
                         {mem_cen, if_vld, ls_vld, if_gnt, ls_gnt});
            else n_pass++;
        end
    endtask

    task automatic test_if_only;
        drive(1'b1, 30'h100, 1'b0, 1'b0, '0);
        n_total++;
        if ({if_gnt, mem_cen} !== 2'b10 || mem_a !== 30'h100)
            $display("FAIL if_only_grant: got gnt=%b cen=%b a=%h want 1 0 100", if_gnt, mem_cen, mem_a);
        else n_pass++;
        drive(1'b0, 30'h100, 1'b0, 1'b0, '0);
        n_total++;
        if (if_vld !== 1'b1 || if_data !== 32'hDEADBEEF || ls_vld !== 1'b0)
            $display("FAIL if_only_resp: got vld=%b data=%h lsv=%b want 1 deadbeef 0", if_vld, if_data, ls_vld);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_contention;
        logic [9:0] pat;
        pat = 10'b10000_10000;  // bit i set: LS wins cycle i
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 30'h80 + AW'(i), 1'b0, 1'b1, 30'h40);
            n_total++;
            if (ls_gnt !== pat[i] || if_gnt !== ~pat[i])
                $display("FAIL contention_c%0d: got if=%b ls=%b want ls=%b", i, if_gnt, ls_gnt, pat[i]);
            else n_pass++;
        end
        idle(2);
    endtask

    task automatic test_flush;
        drive(1'b1, 30'h20, 1'b0, 1'b0, '0);
        drive(1'b0, 30'h20, 1'b1, 1'b1, 30'h24);
        n_total++;
        if (if_vld !== 1'b0 || ls_gnt !== 1'b1)
            $display("FAIL flush_return: got ifv=%b lsg=%b want 0 1", if_vld, ls_gnt);
        else n_pass++;
        drive(1'b0, 30'h20, 1'b0, 1'b0, 30'h24);
        n_total++;
        if (ls_vld !== 1'b1 || ls_data !== word(30'h24))
            $display("FAIL flush_ls: got vld=%b data=%h want 1 %h", ls_vld, ls_data, word(30'h24));
        else n_pass++;
        // flush in the grant cycle: access happens, response suppressed
        drive(1'b1, 30'h30, 1'b1, 1'b0, '0);
        n_total++;
        if (mem_cen !== 1'b0 || if_gnt !== 1'b1)
            $display("FAIL flush_grant_access: got cen=%b gnt=%b want 0 1", mem_cen, if_gnt);
        else n_pass++;
        drive(1'b0, 30'h30, 1'b0, 1'b0, '0);
        n_total++;
        if (if_vld !== 1'b0) $display("FAIL flush_grant_kill: got %b want 0", if_vld);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 30'h0, 1'b0, 1'b0, '0);
        drive(1'b0, 30'h0, 1'b0, 1'b1, 30'h4);
        n_total++;
        if (if_vld !== 1'b1 || if_data !== word(30'h0))
            $display("FAIL b2b_if0: got vld=%b data=%h want 1 %h", if_vld, if_data, word(30'h0));
        else n_pass++;
        drive(1'b1, 30'h8, 1'b0, 1'b0, 30'h4);
        n_total++;
        if (ls_vld !== 1'b1 || if_vld !== 1'b0 || ls_data !== word(30'h4))
            $display("FAIL b2b_ls4: got lsv=%b ifv=%b data=%h want 1 0 %h", ls_vld, if_vld, ls_data, word(30'h4));
        else n_pass++;
        drive(1'b0, 30'h8, 1'b0, 1'b0, 30'h4);
        n_total++;
        if (if_vld !== 1'b1 || if_data !== word(30'h8))
            $display("FAIL b2b_if8: got vld=%b data=%h want 1 %h", if_vld, if_data, word(30'h8));
        else n_pass++;
        idle(2);
    endtask

    task automatic test_async_reset;
        // build up some starvation, then reset with an IF read in flight
        for (int i = 0; i < 3; i++) drive(1'b1, 30'h44, 1'b0, 1'b1, 30'h48);
        #1 sys_rst = 1'b1;
        drive(1'b0, 30'h44, 1'b0, 1'b0, 30'h48);
        n_total++;
        if (if_vld !== 1'b0) $display("FAIL rst_mid_read: got if_vld=%b want 0", if_vld);
        else n_pass++;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 30'h50, 1'b0, 1'b1, 30'h54);
            n_total++;
            if (ls_gnt !== (i == 4) || if_gnt !== (i != 4))
                $display("FAIL rst_contend_c%0d: got if=%b ls=%b want ls=%b", i, if_gnt, ls_gnt, i == 4);
            else n_pass++;
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_contention();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
